// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, decode port and redirect input.
// Carries fetch_misaligned only when MISALIGN_TRAP_EN is defined.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            id_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
`ifdef MISALIGN_TRAP_EN
  logic            fetch_misaligned;
`endif

  modport master (
    input  imem_ready,
    input  imem_rdata,
    input  id_ready,
    input  redirect_valid,
    input  redirect_target,
    output imem_req,
    output imem_addr,
    output if_valid,
    output if_pc,
    output if_instr
`ifdef MISALIGN_TRAP_EN
    , output fetch_misaligned
`endif
  );

  modport slave (
    output imem_ready,
    output imem_rdata,
    output id_ready,
    output redirect_valid,
    output redirect_target,
    input  imem_req,
    input  imem_addr,
    input  if_valid,
    input  if_pc,
    input  if_instr
`ifdef MISALIGN_TRAP_EN
    , input fetch_misaligned
`endif
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch stage (FETCH/VALID handshake FSM).
// Optional MISALIGN_TRAP_EN adds a sticky TRAP state for misaligned redirects.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_unit_if.master bus
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_TRAP  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1
  } state_t;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_instr;
  logic            w_cap;
  logic            w_redir;
  logic [XLEN-1:0] w_tgt;

`ifdef MISALIGN_TRAP_EN
  logic r_mis;
  logic w_mis_set;
  logic w_mis;

  assign w_redir = bus.redirect_valid && (r_state != S_TRAP);
  assign w_tgt   = bus.redirect_target;
  assign w_mis   = |bus.redirect_target[1:0];
  assign bus.fetch_misaligned = r_mis;
`else
  assign w_redir = bus.redirect_valid;
  // Low bits dropped so the PC stays word aligned
  assign w_tgt   = bus.redirect_target & ~XLEN'(3);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cap       = 1'b0;
`ifdef MISALIGN_TRAP_EN
    w_mis_set   = 1'b0;
`endif
    if (w_redir) begin
      w_pc_nxt    = w_tgt;
      w_state_nxt = S_FETCH;
`ifdef MISALIGN_TRAP_EN
      if (w_mis) begin
        w_state_nxt = S_TRAP;
        w_mis_set   = 1'b1;
      end
`endif
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (bus.imem_ready) begin
            w_cap       = 1'b1;
            w_pc_nxt    = r_pc + XLEN'(PC_STEP);
            w_state_nxt = S_VALID;
          end
        end
        S_VALID: begin
          if (bus.id_ready) begin
            w_state_nxt = S_FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_if_pc    <= '0;
      r_if_instr <= '0;
`ifdef MISALIGN_TRAP_EN
      r_mis      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_cap) begin
        r_if_pc    <= r_pc;
        r_if_instr <= bus.imem_rdata;
      end
`ifdef MISALIGN_TRAP_EN
      if (w_mis_set) begin
        r_mis <= 1'b1;
      end
`endif
    end
  end

  assign bus.imem_req  = (r_state == S_FETCH);
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = (r_state == S_VALID);
  assign bus.if_pc     = r_if_pc;
  assign bus.if_instr  = r_if_instr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: fetch and decode queues checked by
// a negedge monitor, plus directed checks for hold, redirect, wrap and reset.
module tb_pc_fetch_unit;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [31:0] fq[$];
  logic [63:0] dq[$];

  pc_fetch_unit_if #(.XLEN(32)) bus ();
  pc_fetch_unit_if #(.XLEN(32)) bus2 ();

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  assign bus.imem_rdata = {bus.imem_addr[23:0], 8'h13};

  assign bus2.imem_rdata      = 32'h0000_0013;
  assign bus2.imem_ready      = 1'b1;
  assign bus2.id_ready        = 1'b1;
  assign bus2.redirect_valid  = 1'b0;
  assign bus2.redirect_target = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_req && bus.imem_ready && !bus.redirect_valid) begin
        if (fq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL fetch_unexpected: got addr %h expected none",
                   bus.imem_addr);
        end else begin
          chk("fetch_addr", bus.imem_addr, fq.pop_front());
        end
      end
      if (bus.if_valid && bus.id_ready && !bus.redirect_valid) begin
        if (dq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL decode_unexpected: got pc %h expected none",
                   bus.if_pc);
        end else begin
          logic [63:0] e;
          e = dq.pop_front();
          chk("decode_pc", bus.if_pc, e[63:32]);
          chk("decode_instr", bus.if_instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.imem_ready      = 1'b0;
    bus.id_ready        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, bus.imem_req}, 32'h1);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_mis", {31'h0, bus.fetch_misaligned}, 32'h0);
`endif

    // Streaming with both sides always ready
    fq.push_back(32'h0);
    fq.push_back(32'h4);
    fq.push_back(32'h8);
    dq.push_back({32'h0, 32'h0000_0013});
    dq.push_back({32'h4, 32'h0000_0413});
    dq.push_back({32'h8, 32'h0000_0813});
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    bus.id_ready   = 1'b1;
    step();
    chk("wrap_if_pc", bus2.if_pc, 32'hFFFF_FFFC);
    chk("wrap_valid", {31'h0, bus2.if_valid}, 32'h1);
    chk("wrap_next_addr", bus2.imem_addr, 32'h0);
    repeat (5) step();
    bus.imem_ready = 1'b0;

    // Decode backpressure
    fq.push_back(32'hC);
    bus.imem_ready = 1'b1;
    bus.id_ready   = 1'b0;
    step();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'h0, bus.if_valid}, 32'h1);
      chk("hold_pc", bus.if_pc, 32'hC);
      chk("hold_instr", bus.if_instr, 32'h0000_0C13);
      chk("hold_noreq", {31'h0, bus.imem_req}, 32'h0);
      step();
    end
    dq.push_back({32'hC, 32'h0000_0C13});
    bus.id_ready = 1'b1;
    step();
    chk("bp_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("bp_req", {31'h0, bus.imem_req}, 32'h1);
    chk("bp_addr", bus.imem_addr, 32'h10);

    // Redirect in FETCH with a same-cycle memory response
    bus.imem_ready      = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_ready     = 1'b0;
    chk("rf_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("rf_req", {31'h0, bus.imem_req}, 32'h1);
    chk("rf_addr", bus.imem_addr, 32'h100);
    fq.push_back(32'h100);
    dq.push_back({32'h100, 32'h0001_0013});
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    step();
    chk("rf_next_addr", bus.imem_addr, 32'h104);

    // Redirect in VALID squashes the presented instruction
    fq.push_back(32'h104);
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready      = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    chk("rv_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("rv_req", {31'h0, bus.imem_req}, 32'h1);
    chk("rv_addr", bus.imem_addr, 32'h40);
    fq.push_back(32'h40);
    dq.push_back({32'h40, 32'h0000_4013});
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    step();
    chk("rv_next_addr", bus.imem_addr, 32'h44);

    // Misaligned redirect
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    chk("trap_mis", {31'h0, bus.fetch_misaligned}, 32'h1);
    chk("trap_req", {31'h0, bus.imem_req}, 32'h0);
    chk("trap_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("trap_addr", bus.imem_addr, 32'h102);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    bus.imem_ready      = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_ready     = 1'b0;
    step();
    chk("trap_hold_addr", bus.imem_addr, 32'h102);
    chk("trap_hold_req", {31'h0, bus.imem_req}, 32'h0);
    chk("trap_hold_mis", {31'h0, bus.fetch_misaligned}, 32'h1);
`else
    chk("mis_addr", bus.imem_addr, 32'h100);
    chk("mis_req", {31'h0, bus.imem_req}, 32'h1);
`endif

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_req", {31'h0, bus.imem_req}, 32'h1);
    chk("arst_valid", {31'h0, bus.if_valid}, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("arst_mis", {31'h0, bus.fetch_misaligned}, 32'h0);
`endif
    step();
    rst = 1'b0;
    step();

    chk("fetch_q_empty", fq.size(), 32'h0);
    chk("decode_q_empty", dq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
